// File: rtl/shift_add_multiplication_v1_0.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Fixed latency of inout_width RUN cycles plus one DONE cycle. Operands are captured only
// when the block is idle.
module shift_add_multiplication_v1_0 #(
  parameter int unsigned inout_width = 12
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic [inout_width-1:0]   multiplicand,
  input  logic [inout_width-1:0]   multiplier,
  input  logic [inout_width-1:0]   addend,
  input  logic                     i_data_valid,
  output logic [2*inout_width-1:0] product,
  output logic                     o_data_ready,
  output logic                     o_data_valid,
  output logic                     error_ovf
);

  localparam int unsigned ProdW = 2 * inout_width;
  localparam int unsigned CntW  = $clog2(inout_width + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ProdW-1:0]       a_q, a_d;
  logic [inout_width-1:0] b_q, b_d;
  logic [ProdW-1:0]       acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ProdW-1:0]       product_d;
  logic                   error_ovf_d;
  logic                   o_data_valid_d;

  // Ready is purely a decode of the idle state.
  assign o_data_ready = (state_q == StIdle);

  // Next-state and datapath: accept in idle, one partial product per run cycle, publish in done.
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    product_d      = product;
    error_ovf_d    = error_ovf;
    o_data_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_data_valid) begin
          a_d     = ProdW'(multiplicand);
          b_d     = multiplier;
          acc_d   = ProdW'(addend);
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Max result is 2^(2N) - 2^N, so this sum never wraps.
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // Always run the full width: no early exit when b_q runs out of ones.
        if (cnt_q == CntW'(inout_width - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        product_d      = acc_q;
        error_ovf_d    = |acc_q[ProdW-1:inout_width];
        o_data_valid_d = 1'b1;
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any calculation in flight.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      product      <= '0;
      error_ovf    <= 1'b0;
      o_data_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      product      <= product_d;
      error_ovf    <= error_ovf_d;
      o_data_valid <= o_data_valid_d;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplication_v1_0.sv
// Self-checking bench for shift_add_multiplication_v1_0 with inout_width = 12.
// Expected results are queued at acceptance and checked when o_data_valid pulses.
module tb_shift_add_multiplication_v1_0;

  localparam int unsigned W = 12;

  logic           aclk;
  logic           reset;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   addend;
  logic           i_data_valid;
  logic [2*W-1:0] product;
  logic           o_data_ready;
  logic           o_data_valid;
  logic           error_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_valid_cyc = 0;

  typedef struct {
    logic [2*W-1:0] p;
    logic           o;
    int             acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  shift_add_multiplication_v1_0 #(
    .inout_width(W)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .addend      (addend),
    .i_data_valid(i_data_valid),
    .product     (product),
    .o_data_ready(o_data_ready),
    .o_data_valid(o_data_valid),
    .error_ovf   (error_ovf)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Result monitor: every pulse must match the oldest outstanding request.
  always @(negedge aclk) begin
    if (!reset && o_data_valid) begin
      last_valid_cyc = cyc;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid: got pulse at cycle %0d, expected none", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (product === e.p) else begin
          errors++;
          $error("FAIL product: got %0d expected %0d", product, e.p);
        end
        checks++;
        assert (error_ovf === e.o) else begin
          errors++;
          $error("FAIL error_ovf: got %0b expected %0b", error_ovf, e.o);
        end
        checks++;
        assert (cyc - e.acc_cyc == W + 1) else begin
          errors++;
          $error("FAIL latency: got %0d expected %0d", cyc - e.acc_cyc, W + 1);
        end
      end
    end
  end

  // Called at posedge+1; waits (bounded) for ready, then presents one request.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [2*W-1:0] ep, input logic eo);
    int n = 0;
    while (!o_data_ready && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    checks++;
    assert (o_data_ready === 1'b1) else begin
      errors++;
      $error("FAIL ready_wait: got %0b expected 1", o_data_ready);
    end
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    i_data_valid = 1'b1;
    @(posedge aclk); #1;
    sb.push_back('{p: ep, o: eo, acc_cyc: cyc});
    i_data_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b) + (2*W)'(c);
    send(a, b, c, p, |p[2*W-1:W]);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_data_valid && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    checks++;
    assert (o_data_valid === 1'b1) else begin
      errors++;
      $error("FAIL wait_valid: got %0b expected 1", o_data_valid);
    end
  endtask

  initial begin
    int first_cyc;
    int pulses;
    reset        = 1'b1;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;
    i_data_valid = 1'b0;
    #3;
    checks++;
    assert (product === '0) else begin
      errors++; $error("FAIL reset_product: got %0h expected 0", product);
    end
    checks++;
    assert (o_data_valid === 1'b0 && error_ovf === 1'b0) else begin
      errors++; $error("FAIL reset_flags: got v=%0b o=%0b expected 0 0", o_data_valid, error_ovf);
    end
    checks++;
    assert (o_data_ready === 1'b1) else begin
      errors++; $error("FAIL reset_ready: got %0b expected 1", o_data_ready);
    end
    @(posedge aclk); @(posedge aclk); #1;
    reset = 1'b0;

    // Basic and boundary cases.
    send(12'd7, 12'd9, 12'd3, 24'd66, 1'b0);
    drain();
    send(12'd4095, 12'd4095, 12'd4095, 24'hFFF000, 1'b1);
    drain();
    send(12'd7, 12'd14, 12'd2, 24'd100, 1'b0);
    drain();
    send(12'd1234, 12'd0, 12'd5, 24'd5, 1'b0);
    drain();
    send(12'd0, 12'd4095, 12'd77, 24'd77, 1'b0);
    drain();

    // Busy rejection: new request during RUN must be ignored.
    send(12'd7, 12'd9, 12'd3, 24'd66, 1'b0);
    @(posedge aclk); #1;
    checks++;
    assert (o_data_ready === 1'b0) else begin
      errors++; $error("FAIL busy_ready: got %0b expected 0", o_data_ready);
    end
    multiplicand = 12'd100;
    multiplier   = 12'd100;
    addend       = 12'd100;
    i_data_valid = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
    end
    i_data_valid = 1'b0;
    drain();
    repeat (4) begin
      @(posedge aclk); #1;
    end

    // Back-to-back: second request issued in the o_data_valid cycle.
    send(12'd7, 12'd14, 12'd2, 24'd100, 1'b0);
    wait_valid();
    first_cyc = cyc;
    send(12'd1234, 12'd0, 12'd5, 24'd5, 1'b0);
    wait_valid();
    checks++;
    assert (cyc - first_cyc == W + 2) else begin
      errors++; $error("FAIL b2b_spacing: got %0d expected %0d", cyc - first_cyc, W + 2);
    end
    drain();

    // Reset mid-RUN discards the calculation.
    send(12'd4095, 12'd4095, 12'd4095, 24'hFFF000, 1'b1);
    drain();
    send(12'd5, 12'd6, 12'd7, 24'd37, 1'b0);
    repeat (4) begin
      @(posedge aclk); #1;
    end
    reset = 1'b1;
    #1;
    sb.delete();
    checks++;
    assert (product === '0 && error_ovf === 1'b0 && o_data_valid === 1'b0) else begin
      errors++;
      $error("FAIL midrun_reset_out: got p=%0h o=%0b v=%0b expected 0 0 0",
             product, error_ovf, o_data_valid);
    end
    checks++;
    assert (o_data_ready === 1'b1) else begin
      errors++; $error("FAIL midrun_reset_ready: got %0b expected 1", o_data_ready);
    end
    @(posedge aclk); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge aclk); #1;
      if (o_data_valid) pulses++;
    end
    checks++;
    assert (pulses == 0) else begin
      errors++; $error("FAIL midrun_no_pulse: got %0d pulses expected 0", pulses);
    end

    // First request after reset is accepted; random operands against the model.
    for (int i = 0; i < 6; i++) begin
      send_model(W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)),
                 W'($urandom_range(0, 4095)));
      drain();
    end
    send_model(12'd64, 12'd63, 12'd4095);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
